// File: rtl/ycc_block_sched_pkg.sv
// Shared types for the Y/Cb/Cr block serializer.
package ycc_block_sched_pkg;

  localparam int BEATS_DEF = 32;

  typedef enum logic [1:0] {
    COMP_Y  = 2'd0,
    COMP_CB = 2'd1,
    COMP_CR = 2'd2
  } comp_t;

  typedef enum logic [1:0] {
    PASS_Y  = 2'd0,
    PLAY_CB = 2'd1,
    PLAY_CR = 2'd2
  } state_t;

endpackage

// File: rtl/ycc_block_sched_blk_store.sv
// One component block held in flops: synchronous write, combinational read.
module blk_store #(
  parameter int N     = 2,
  parameter int BEATS = 32,
  parameter int AW    = 5
) (
  input  logic                clk,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [N-1:0][7:0]   wdata,
  input  logic [AW-1:0]       raddr,
  output logic [N-1:0][7:0]   rdata
);

  logic [N-1:0][7:0] mem [BEATS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ycc_block_sched.sv
// Serializes parallel Y/Cb/Cr 8x8 blocks into Y, then Cb, then Cr blocks.
module ycc_block_sched
  import ycc_block_sched_pkg::*;
#(
  parameter int N     = 2,
  parameter int BEATS = BEATS_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [N-1:0][7:0]  in_data_y,
  input  logic signed [N-1:0][7:0]  in_data_cb,
  input  logic signed [N-1:0][7:0]  in_data_cr,
  input  logic                      in_sob,
  input  logic                      in_eob,
  input  logic                      in_sof,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [N-1:0][7:0]  out_data,
  output logic [1:0]                out_comp,
  output logic                      out_sob,
  output logic                      out_eob,
  output logic                      out_sof,
  output logic                      proto_err
);

  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  state_t            state;
  logic [CW-1:0]     cnt;
  logic              first;
  logic              last;
  logic              drop;
  logic              acc;
  logic              adv;
  logic              we;
  logic              err_d;
  logic [N-1:0][7:0] cb_rd;
  logic [N-1:0][7:0] cr_rd;

  assign first = (cnt == '0);
  assign last  = (cnt == LAST);

  // A block may only open on a beat flagged sob; anything else is swallowed.
  assign drop = (state == PASS_Y) && first && !in_sob;

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = in_data_y;
    out_comp  = COMP_Y;
    if (!rst) begin
      unique case (state)
        PASS_Y: begin
          in_ready  = drop | out_ready;
          out_valid = in_valid & ~drop;
        end
        PLAY_CB: begin
          out_valid = 1'b1;
          out_data  = cb_rd;
          out_comp  = COMP_CB;
        end
        PLAY_CR: begin
          out_valid = 1'b1;
          out_data  = cr_rd;
          out_comp  = COMP_CR;
        end
        default: ;
      endcase
    end
  end

  assign out_sob = out_valid & first;
  assign out_eob = out_valid & last;
  assign out_sof = out_valid & (state == PASS_Y) & first & in_sof;

  assign acc = in_valid & in_ready;
  assign we  = (state == PASS_Y) & acc & ~drop;
  assign adv = (state == PASS_Y) ? we : out_ready;

  assign err_d = (state == PASS_Y) & acc &
                 (drop |
                  (last & ~in_eob) |
                  (~first & ~last & (in_sob | in_eob)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= PASS_Y;
      cnt       <= '0;
      proto_err <= 1'b0;
    end else begin
      proto_err <= err_d;
      if (adv) begin
        cnt <= last ? '0 : cnt + CW'(1);
        if (last) begin
          unique case (state)
            PASS_Y:  state <= PLAY_CB;
            PLAY_CB: state <= PLAY_CR;
            PLAY_CR: state <= PASS_Y;
            default: state <= PASS_Y;
          endcase
        end
      end
    end
  end

  blk_store #(.N(N), .BEATS(BEATS), .AW(CW)) u_cb (
    .clk   (clk),
    .we    (we),
    .waddr (cnt),
    .wdata (in_data_cb),
    .raddr (cnt),
    .rdata (cb_rd)
  );

  blk_store #(.N(N), .BEATS(BEATS), .AW(CW)) u_cr (
    .clk   (clk),
    .we    (we),
    .waddr (cnt),
    .wdata (in_data_cr),
    .raddr (cnt),
    .rdata (cr_rd)
  );

endmodule

// File: tb/tb_ycc_block_sched.sv
// Randomized bench for ycc_block_sched against a queue-based block model.
module tb_ycc_block_sched;
  import ycc_block_sched_pkg::*;

  localparam int N     = 2;
  localparam int BEATS = 32;

  typedef logic [N-1:0][7:0] pix_t;
  typedef struct packed {
    logic [1:0] comp;
    pix_t       data;
    logic       sob;
    logic       eob;
    logic       sof;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  pix_t in_y = '0, in_cb = '0, in_cr = '0;
  logic in_sob = 1'b0, in_eob = 1'b0, in_sof = 1'b0;
  logic out_valid;
  logic out_ready = 1'b1;
  pix_t out_data;
  logic [1:0] out_comp;
  logic out_sob, out_eob, out_sof, proto_err;

  ycc_block_sched #(.N(N), .BEATS(BEATS)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data_y  (in_y),
    .in_data_cb (in_cb),
    .in_data_cr (in_cr),
    .in_sob     (in_sob),
    .in_eob     (in_eob),
    .in_sof     (in_sof),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_comp   (out_comp),
    .out_sob    (out_sob),
    .out_eob    (out_eob),
    .out_sof    (out_sof),
    .proto_err  (proto_err)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    failures = 0;
  beat_t exp_q[$];
  int    n_out, n_sob, n_eob, n_sof, n_err;
  bit    rnd_ready = 1'b0;
  bit    stalled = 1'b0;
  beat_t prev_b;
  int    log_comp[$];
  pix_t  log_data[$];
  bit    log_sof[$];
  bit    log_sob[$];
  int    t1_comp[$];
  pix_t  t1_data[$];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(posedge clk) begin
    #1;
    out_ready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  always @(negedge clk) begin
    beat_t cur, e;
    cur = {out_comp, out_data, out_sob, out_eob, out_sof};
    if (rst) begin
      chk("rst_outputs", {out_valid, in_ready}, 2'b00);
      stalled = 1'b0;
    end else begin
      if (stalled)
        chk("stall_hold", {out_valid, cur}, {1'b1, prev_b});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("beat", cur, e);
        end
        n_out++;
        n_sob += int'(out_sob);
        n_eob += int'(out_eob);
        n_sof += int'(out_sof);
        log_comp.push_back(int'(out_comp));
        log_data.push_back(out_data);
        log_sof.push_back(out_sof);
        log_sob.push_back(out_sob);
      end
      if (proto_err) n_err++;
      stalled = out_valid && !out_ready;
      prev_b  = cur;
    end
  end

  task automatic clear_counts();
    n_out = 0; n_sob = 0; n_eob = 0; n_sof = 0; n_err = 0;
    log_comp.delete(); log_data.delete();
    log_sof.delete(); log_sob.delete();
  endtask

  task automatic send_beat(input pix_t y, input pix_t cb, input pix_t cr,
                           input bit sob, input bit eob, input bit sof,
                           input int gap, output int t);
    bit done = 1'b0;
    t = -1;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #2;
    end
    in_valid = 1'b1;
    in_y = y; in_cb = cb; in_cr = cr;
    in_sob = sob; in_eob = eob; in_sof = sof;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        t = int'($time / 10);
        done = 1'b1;
      end
      @(posedge clk); #2;
    end
    in_valid = 1'b0;
    chk("accept_in_time", done, 1);
  endtask

  // mode 0: ramp data, mode 1: random data
  task automatic send_block(input int mode, input bit sof, input int eob_at,
                            input int max_gap, output int t0);
    pix_t y[BEATS], cb[BEATS], cr[BEATS];
    beat_t e;
    int t;
    for (int k = 0; k < BEATS; k++) begin
      if (mode == 0) begin
        y[k]  = {N{8'(k)}};
        cb[k] = {N{8'(8'h40 + k)}};
        cr[k] = {N{8'(8'h80 + k)}};
      end else begin
        y[k]  = pix_t'($urandom);
        cb[k] = pix_t'($urandom);
        cr[k] = pix_t'($urandom);
      end
    end
    for (int c = 0; c < 3; c++)
      for (int k = 0; k < BEATS; k++) begin
        e.comp = 2'(c);
        e.data = (c == 0) ? y[k] : (c == 1) ? cb[k] : cr[k];
        e.sob  = (k == 0);
        e.eob  = (k == BEATS - 1);
        e.sof  = (c == 0) && (k == 0) && sof;
        exp_q.push_back(e);
      end
    t0 = -1;
    for (int k = 0; k < BEATS; k++) begin
      send_beat(y[k], cb[k], cr[k], k == 0,
                (k == BEATS - 1) || (k == eob_at), sof && (k == 0),
                (max_gap > 0) ? $urandom_range(0, max_gap) : 0, t);
      if (k == 0) t0 = t;
    end
  endtask

  task automatic drain();
    int i = 0;
    while (exp_q.size() != 0 && i < 5000) begin
      @(posedge clk);
      i++;
    end
    chk("drain_left", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #2;
  endtask

  initial begin
    int ta, tb, diffs, ny, cb_seen, t;
    bit done;

    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("idle_out_valid", out_valid, 0);
    chk("idle_proto_err", proto_err, 0);
    #1;

    // back-to-back ramp blocks
    clear_counts();
    rnd_ready = 1'b0;
    send_block(0, 1'b0, -1, 0, ta);
    send_block(0, 1'b0, -1, 0, tb);
    drain();
    chk("b2b_out_count", n_out, 192);
    chk("b2b_block_period", tb - ta, 96);
    chk("b2b_err", n_err, 0);
    if (log_comp.size() == 192) begin
      chk("pin_beat0", {log_comp[0], log_data[0]}, {32'd0, 16'h0000});
      chk("pin_beat40", {log_comp[40], log_data[40]}, {32'd1, 16'h4848});
      chk("pin_beat95", {log_comp[95], log_data[95]}, {32'd2, 16'h9f9f});
      chk("pin_beat96", {log_comp[96], log_data[96]}, {32'd0, 16'h0000});
      chk("pin_beat191", {log_comp[191], log_data[191]}, {32'd2, 16'h9f9f});
    end
    t1_comp = log_comp;
    t1_data = log_data;

    // same blocks under random backpressure
    clear_counts();
    rnd_ready = 1'b1;
    send_block(0, 1'b0, -1, 0, ta);
    send_block(0, 1'b0, -1, 0, tb);
    drain();
    chk("bp_out_count", n_out, 192);
    diffs = 0;
    for (int i = 0; i < log_comp.size() && i < t1_comp.size(); i++)
      if (log_comp[i] != t1_comp[i] || log_data[i] != t1_data[i]) diffs++;
    chk("bp_seq_diff", diffs, 0);

    // framing
    clear_counts();
    send_block(0, 1'b1, -1, 0, ta);
    send_block(0, 1'b0, -1, 0, tb);
    drain();
    chk("sof_count", n_sof, 1);
    chk("sob_count", n_sob, 6);
    chk("eob_count", n_eob, 6);
    if (log_sof.size() > 0) chk("sof_first", log_sof[0], 1);

    // missing sob
    clear_counts();
    for (int g = 0; g < 3; g++)
      send_beat(pix_t'($urandom), pix_t'($urandom), pix_t'($urandom),
                1'b0, 1'b0, 1'b0, 0, t);
    send_block(1, 1'b0, -1, 0, ta);
    drain();
    chk("garbage_err", n_err, 3);
    chk("garbage_out_count", n_out, 96);
    if (log_sob.size() > 0)
      chk("garbage_first", {log_comp[0], log_sob[0]}, {32'd0, 1'b1});

    // early eob
    clear_counts();
    send_block(1, 1'b0, 10, 0, ta);
    drain();
    chk("early_eob_err", n_err, 1);
    chk("early_eob_out", n_out, 96);
    ny = 0;
    foreach (log_comp[i]) if (log_comp[i] == 0) ny++;
    chk("early_eob_y", ny, 32);

    // reset in the middle of the Cb replay
    clear_counts();
    rnd_ready = 1'b0;
    send_block(0, 1'b0, -1, 0, ta);
    cb_seen = 0;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (out_valid && out_comp == 2'd1) begin
        if (cb_seen == 5) begin
          chk("rst_cb5_data", out_data, 16'h4545);
          rst = 1'b1;
          #1;
          chk("rst_drop_valid", out_valid, 0);
          done = 1'b1;
        end else begin
          cb_seen++;
        end
      end
      if (!done) begin
        @(posedge clk); #2;
      end
    end
    chk("rst_reached_cb5", done, 1);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    clear_counts();
    send_block(0, 1'b1, -1, 0, ta);
    drain();
    chk("post_rst_out", n_out, 96);
    chk("post_rst_err", n_err, 0);
    if (log_comp.size() > 0)
      chk("post_rst_first", {log_comp[0], log_sob[0], log_sof[0]},
          {32'd0, 1'b1, 1'b1});

    // random blocks, random gaps, random backpressure
    clear_counts();
    rnd_ready = 1'b1;
    for (int b = 0; b < 4; b++)
      send_block(1, $urandom_range(0, 1) == 1, -1, 2, ta);
    drain();
    chk("rand_out_count", n_out, 384);
    chk("rand_err", n_err, 0);
    chk("rand_sob", n_sob, 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ycc_block_sched.md
YCC_BLOCK_SCHED -- requirements
Module: ycc_block_sched

Interface
REQ-001 SHALL have parameter N, default 2: pixels per beat.
REQ-002 SHALL have parameter BEATS, default 32: beats per 8x8 block; BEATS*N SHALL equal 64.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  upstream beat valid (upstream is the block buffer output).
REQ-006 in_ready  output  1  beat accepted when in_valid && in_ready.
REQ-007 in_data_y, in_data_cb, in_data_cr  input  N x 8 signed each  component pixels.
REQ-008 in_sob, in_eob, in_sof  input  1 each  start of block, end of block, start of frame.
REQ-009 out_valid  output  1  downstream beat valid.
REQ-010 out_ready  input  1  downstream accepts when out_valid && out_ready.
REQ-011 out_data  output  N x 8 signed  serialized component pixels.
REQ-012 out_comp  output  2  component tag: 0 = Y, 1 = Cb, 2 = Cr; 3 never driven.
REQ-013 out_sob, out_eob, out_sof  output  1 each  framing of the serialized stream.
REQ-014 proto_err  output  1  one-cycle pulse on an input framing violation.

Function
REQ-015 SHALL serialize each parallel Y/Cb/Cr block into three consecutive component blocks, in the order Y, Cb, Cr.
REQ-016 SHALL implement FSM states PASS_Y, PLAY_CB and PLAY_CR, with a beat counter cnt in 0..BEATS-1.
REQ-017 In PASS_Y, these SHALL be combinational: in_ready = out_ready, out_valid = in_valid, out_data = in_data_y, out_comp = 0; zero-cycle latency.
REQ-018 In PASS_Y, each accepted beat SHALL write in_data_cb and in_data_cr into two local flop arrays at index cnt, then increment cnt.
REQ-019 In PLAY_CB and PLAY_CR: in_ready = 0, out_valid = 1; out_data is read combinationally from the Cb or Cr array at index cnt; cnt increments on each out_ready.
REQ-020 Transitions:
- PASS_Y -> PLAY_CB on the accepted beat with cnt = BEATS-1.
- PLAY_CB -> PLAY_CR on the handshake with cnt = BEATS-1.
- PLAY_CR -> PASS_Y on the handshake with cnt = BEATS-1.
- cnt wraps to 0 on every transition.
REQ-021 out_sob SHALL be 1 when cnt = 0 and out_eob SHALL be 1 when cnt = BEATS-1, in every state, qualified by out_valid.
REQ-022 out_sof SHALL equal in_sof on the PASS_Y cnt = 0 beat and SHALL be 0 on all Cb/Cr beats.
REQ-023 In PASS_Y with cnt = 0, a valid beat without in_sob SHALL be consumed, discarded and not forwarded (out_valid = 0, in_ready = 1), with a proto_err pulse; cnt stays 0.
REQ-024 When cnt = BEATS-1, in_eob = 0 on the accepted beat SHALL pulse proto_err; the block still closes at cnt = BEATS-1.
REQ-025 When cnt != 0 and != BEATS-1, an accepted beat with in_sob or in_eob set SHALL pulse proto_err; the beat is still processed as a normal beat at position cnt.
REQ-026 Sustained throughput SHALL be one block per 3*BEATS cycles when in_valid and out_ready are held high; there SHALL be no idle cycle between components or blocks.
REQ-027 out_data, out_comp and all framing outputs SHALL be held stable while out_valid && !out_ready, including in PASS_Y (which relies on upstream also holding stable).

Reset
REQ-028 On rst: state = PASS_Y, cnt = 0, proto_err = 0, array contents unspecified.
REQ-029 While rst is asserted, out_valid = 0 and in_ready = 0.
REQ-030 Reset mid-block SHALL abandon the block with no further Cb/Cr replay; the next beat with in_sob after rst deasserts starts a new block.

Structure
REQ-031 A shared package SHALL hold the comp_t enum (COMP_Y, COMP_CB, COMP_CR), the state enum, and the BEATS default.
REQ-032 One sub-module, blk_store (BEATS x N x 8 flop array with synchronous write and combinational read), SHALL be instantiated twice, once for Cb and once for Cr.

Verification
REQ-033 Back-to-back: 2 blocks, ramp data (y = beat, cb = 0x40 + beat, cr = 0x80 + beat), out_ready = 1 -> 192 output beats, tags 0,1,2 in sequence, data matches the ramp, in_ready low for cycles 32-95.
REQ-034 Backpressure: random out_ready at 50% -> identical output sequence to REQ-033 and no data change while stalled.
REQ-035 Framing: in_sof = 1 on block 1 only -> out_sof high exactly once, on the first Y beat of block 1; 6 sob and 6 eob pulses in total.
REQ-036 Missing sob: 3 garbage beats, then a valid block -> 3 proto_err pulses, 0 garbage beats output, then a normal 96-beat output.
REQ-037 Early eob at beat 10 -> 1 proto_err pulse and a full 32-beat Y block still output.
REQ-038 rst asserted at Cb beat 5 -> out_valid drops immediately; after release the next block outputs Y starting at cnt = 0.
